// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: request / wait / hold sequencing with PC redirect.
// Optional misaligned-redirect trap: define FETCH_MISALIGN_TRAP_EN.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   input  logic        PCSrc,
   input  logic [31:0] branch_target
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic        misaligned
`endif
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_HALT = 2'd3
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_fetch_pc;
   logic        r_discard;
   logic        r_req_valid;
   logic        r_instr_valid;
   logic [31:0] r_instruction;
   logic [31:0] r_instr_pc;

   logic        w_hs;
   logic        w_pending;
   logic        w_outstanding;
   logic        w_bad;
   logic [31:0] w_target;

   // Handshake and redirect qualifiers; w_outstanding means a response is still owed after this edge.
   always_comb begin
      w_hs          = r_req_valid & imem_req_ready;
      w_pending     = (r_state == S_WAIT) | r_discard;
      w_outstanding = w_hs | (w_pending & ~imem_rsp_valid);
      w_target      = branch_target & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
      w_bad         = |branch_target[1:0];
`else
      w_bad         = 1'b0;
`endif
   end

   // Fetch sequencer: redirect wins over every other event in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_REQ;
         r_pc          <= RESET_PC;
         r_fetch_pc    <= 32'h0000_0000;
         r_discard     <= 1'b0;
         r_req_valid   <= 1'b0;
         r_instr_valid <= 1'b0;
         r_instruction <= 32'h0000_0000;
         r_instr_pc    <= 32'h0000_0000;
      end else if (PCSrc) begin
         r_instr_valid <= 1'b0;
         r_discard     <= w_outstanding;
         if (w_bad) begin
            r_state     <= S_HALT;
            r_req_valid <= 1'b0;
         end else begin
            r_pc        <= w_target;
            r_state     <= w_outstanding ? S_WAIT : S_REQ;
            r_req_valid <= ~w_outstanding;
         end
      end else begin
         case (r_state)
            S_REQ: begin
               if (w_hs) begin
                  r_fetch_pc  <= r_pc;
                  r_pc        <= r_pc + 32'd4;
                  r_state     <= S_WAIT;
                  r_req_valid <= 1'b0;
               end else begin
                  r_req_valid <= 1'b1;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  if (r_discard) begin
                     r_discard   <= 1'b0;
                     r_state     <= S_REQ;
                     r_req_valid <= 1'b1;
                  end else begin
                     r_instruction <= imem_rsp_data;
                     r_instr_pc    <= r_fetch_pc;
                     r_instr_valid <= 1'b1;
                     r_state       <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (instr_ready) begin
                  r_instr_valid <= 1'b0;
                  r_state       <= S_REQ;
                  r_req_valid   <= 1'b1;
               end
            end
            S_HALT: begin
               // Drain the response of a request abandoned by the trapping redirect.
               if (imem_rsp_valid) begin
                  r_discard <= 1'b0;
               end
            end
            default: begin
               r_state       <= S_REQ;
               r_req_valid   <= 1'b0;
               r_instr_valid <= 1'b0;
               r_discard     <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   logic r_misaligned;

   // Trap flag: set by a misaligned redirect, cleared by the next aligned one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_misaligned <= 1'b0;
      end else if (PCSrc) begin
         r_misaligned <= w_bad;
      end else begin
         r_misaligned <= r_misaligned;
      end
   end

   assign misaligned = r_misaligned;
`endif

   assign imem_req_valid = r_req_valid;
   assign imem_req_addr  = r_pc;
   assign instr_valid    = r_instr_valid;
   assign instruction    = r_instruction;
   assign instr_pc       = r_instr_pc;

endmodule
